// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared 16-bit CPU types and constants
// Purpose: word width, opcode constants, bubble word, IF/ID register layout
//          and the fetch FSM state encoding used across the front end.
// Ports:   none (package).
// Config:  none; IF_STAGE_PERF_EN is consumed by if_stage and if_stage_if.
package cpu_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_AND = 4'h3,
    OP_OR  = 4'h4,
    OP_LW  = 4'h8,
    OP_SW  = 4'h9,
    OP_BEQ = 4'hC,
    OP_JMP = 4'hD,
    OP_HLT = 4'hF
  } opcode_e;

  // All-zero word doubles as the bubble instruction (opcode NOP).
  localparam logic [WORD_W-1:0] IF_NOP = 16'h0000;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc_plus2;
    logic              valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{instr: IF_NOP, pc_plus2: '0, valid: 1'b0};

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch-stage signal bundle
// Purpose: groups hazard/branch controls, instruction-memory port and IF/ID
//          outputs of the fetch stage.
// Modports: slave  - the fetch stage (takes controls + imem data, drives rest)
//           master - the surrounding pipeline / memory / bench
// Config:  IF_STAGE_PERF_EN adds perf_cycles, perf_fetched, perf_stalls.
interface if_stage_if;
  import cpu_pkg::*;

  logic              stall;
  logic              redirect;
  logic [WORD_W-1:0] redirect_pc;
  logic [WORD_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_data;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] if_id_instr;
  logic [WORD_W-1:0] if_id_pc_plus2;
  logic              if_id_valid;
  logic              fetch_halted;
`ifdef IF_STAGE_PERF_EN
  logic [15:0]       perf_cycles;
  logic [15:0]       perf_fetched;
  logic [15:0]       perf_stalls;
`endif

  modport slave (
    input  stall, redirect, redirect_pc, imem_data,
    output imem_addr, pc, if_id_instr, if_id_pc_plus2, if_id_valid, fetch_halted
`ifdef IF_STAGE_PERF_EN
    , output perf_cycles, perf_fetched, perf_stalls
`endif
  );

  modport master (
    output stall, redirect, redirect_pc, imem_data,
    input  imem_addr, pc, if_id_instr, if_id_pc_plus2, if_id_valid, fetch_halted
`ifdef IF_STAGE_PERF_EN
    , input perf_cycles, perf_fetched, perf_stalls
`endif
  );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// rtl/if_stage_if_id_reg.sv - IF/ID pipeline register
// Purpose: holds the fetched instruction and its PC+2 for decode.
// Ports:   clk, rst_n (sync active-low), i_load (capture new word),
//          i_bubble (insert bubble, wins over i_load), i_instr, i_pc_plus2,
//          o_if_id (registered {instr, pc_plus2, valid}). Neither control = hold.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_bubble,
  input  logic [WORD_W-1:0] i_instr,
  input  logic [WORD_W-1:0] i_pc_plus2,
  output if_id_t            o_if_id
);

  if_id_t r_if_id;

  always_ff @(posedge clk) begin
    if (!rst_n || i_bubble) begin
      r_if_id <= IF_ID_BUBBLE;
    end else if (i_load) begin
      r_if_id <= '{instr: i_instr, pc_plus2: i_pc_plus2, valid: 1'b1};
    end
  end

  assign o_if_id = r_if_id;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage with PC, halt FSM and IF/ID
// Purpose: owns the PC, addresses instruction memory, loads IF/ID, obeys
//          stall/redirect and stops fetching after an HLT.
// Ports:   clk, rst_n (sync active-low), bus (if_stage_if.slave: stall,
//          redirect, redirect_pc, imem_data in; imem_addr, pc, if_id_*,
//          fetch_halted out).
// Config:  IF_STAGE_PERF_EN adds saturating perf_cycles/perf_fetched/perf_stalls.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]        HLT_OPCODE = OP_HLT
) (
  input  logic       clk,
  input  logic       rst_n,
  if_stage_if.slave  bus
);

  logic [WORD_W-1:0] r_pc;
  fetch_state_e      r_state;
  logic              r_halted;
  if_id_t            w_if_id;
  logic [WORD_W-1:0] w_pc_plus2;
  logic              w_is_hlt;
  logic              w_load;
  logic              w_bubble;

  // 16-bit add wraps FFFE -> 0000 naturally.
  assign w_pc_plus2 = r_pc + WORD_W'(2);
  assign w_is_hlt   = (bus.imem_data[15:12] == HLT_OPCODE);

  // Redirect beats stall; a stalled HALTED stage keeps its current bubble.
  assign w_load   = !bus.redirect && !bus.stall && (r_state == ST_RUN);
  assign w_bubble = bus.redirect || (!bus.stall && (r_state == ST_HALTED));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_state  <= ST_RUN;
      r_halted <= 1'b0;
    end else if (bus.redirect) begin
      r_pc     <= bus.redirect_pc;
      r_state  <= ST_RUN;
      r_halted <= 1'b0;
    end else if (!bus.stall) begin
      case (r_state)
        ST_RUN: begin
          if (w_is_hlt) begin
            // PC parks on the HLT so a later redirect is the only way out.
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end else begin
            r_pc <= w_pc_plus2;
          end
        end
        ST_HALTED: begin
          r_pc <= r_pc;
        end
        default: begin
          r_state  <= ST_RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_bubble   (w_bubble),
    .i_instr    (bus.imem_data),
    .i_pc_plus2 (w_pc_plus2),
    .o_if_id    (w_if_id)
  );

  assign bus.imem_addr      = r_pc;
  assign bus.pc             = r_pc;
  assign bus.if_id_instr    = w_if_id.instr;
  assign bus.if_id_pc_plus2 = w_if_id.pc_plus2;
  assign bus.if_id_valid    = w_if_id.valid;
  assign bus.fetch_halted   = r_halted;

`ifdef IF_STAGE_PERF_EN
  logic [15:0] r_perf_cycles;
  logic [15:0] r_perf_fetched;
  logic [15:0] r_perf_stalls;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_cycles  <= '0;
      r_perf_fetched <= '0;
      r_perf_stalls  <= '0;
    end else begin
      if (r_perf_cycles != '1) r_perf_cycles <= r_perf_cycles + 16'd1;
      if (w_load && (r_perf_fetched != '1)) r_perf_fetched <= r_perf_fetched + 16'd1;
      if (bus.stall && !bus.redirect && (r_perf_stalls != '1))
        r_perf_stalls <= r_perf_stalls + 16'd1;
    end
  end

  assign bus.perf_cycles  = r_perf_cycles;
  assign bus.perf_fetched = r_perf_fetched;
  assign bus.perf_stalls  = r_perf_stalls;
`endif

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 16-bit pipelined processor. It owns the architectural PC, drives the instruction-memory read address, and captures each fetched word into the IF/ID pipeline register for decode. It obeys stall and flush/redirect requests from the hazard and branch logic, and detects HLT at fetch so the front end stops cleanly. The `pc` seen at the `cpu` top level is this block's PC register.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `HLT_OPCODE`, 4'hF, opcode in bits [15:12] that marks HLT.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset, sampled on the rising edge.
- `stall` in 1: hold PC and IF/ID (load-use hazard).
- `redirect` in 1: taken branch/jump resolved downstream; flush IF/ID.
- `redirect_pc` in 16: target PC, valid when `redirect`=1.
- `imem_addr` out 16: instruction-memory address, equal to `pc`.
- `imem_data` in 16: instruction word, combinational read of `imem_addr`.
- `pc` out 16: current PC register.
- `if_id_instr` out 16: registered instruction to decode.
- `if_id_pc_plus2` out 16: registered PC+2 of that instruction.
- `if_id_valid` out 1: IF/ID holds a real instruction (0 means bubble).
- `fetch_halted` out 1: front end has stopped after fetching HLT.

## Operation
- FSM with two states: RUN and HALTED. Reset state is RUN.
- Priority per edge: reset > redirect > stall > normal.
- On reset: `pc`=RESET_PC, `if_id_instr`=IF_NOP, `if_id_pc_plus2`=16'h0000, `if_id_valid`=0, state RUN, `fetch_halted`=0.
- On redirect, in either state: `pc`<=`redirect_pc`; IF/ID <= bubble (instr IF_NOP, valid 0, pc_plus2 0); state <= RUN. Redirect overrides a simultaneous stall.
- On stall with no redirect: `pc` and IF/ID hold; the state does not change, and a HLT on `imem_data` is not acted on.
- RUN, normal: IF/ID <= {`imem_data`, `pc`+2, valid 1}; if `imem_data[15:12]`==HLT_OPCODE, `pc` holds and state <= HALTED; otherwise `pc` <= `pc`+2.
- HALTED, normal: `pc` holds and IF/ID <= bubble every cycle. Only a redirect or a reset leaves HALTED. A redirect covers an older branch still in flight that squashes the HLT.
- `fetch_halted` = (state==HALTED).
- Arithmetic: PC+2 is 16-bit modulo, so 16'hFFFE wraps to 16'h0000. `redirect_pc` is taken as-is, and bit 0 is not masked.

## Timing
- Fetch latency is 1 cycle: the word at `pc` appears on `if_id_instr` after the next edge.
- Redirect asserted in cycle N: `pc`=target after edge N and `if_id_valid`=0. The target instruction reaches IF/ID after edge N+1.
- Stall for K cycles freezes all outputs for K edges.
- HLT fetched at edge N: IF/ID holds HLT with valid 1 after edge N, `fetch_halted`=1 after edge N, and bubbles follow from edge N+1.
- `imem_addr` is combinational from the PC register. There is no other combinational path from inputs to outputs.

## Configuration
- `IF_STAGE_PERF_EN` defined adds three 16-bit saturating counters, each cleared by reset:
  - `perf_cycles`: counts every non-reset cycle.
  - `perf_fetched`: counts cycles that load a valid instruction into IF/ID.
  - `perf_stalls`: counts stall cycles in which `redirect`=0.
  - The counters are exposed as output ports of the same names.
- Undefined: the counters and their ports are absent. Fetch behaviour is identical in both builds.

## Structure
- Shared package `cpu_pkg` holds:
  - IF_NOP (16'h0000 bubble word).
  - The opcode constants, including HLT.
  - The 16-bit word width.
  - The IF/ID packed struct {instr, pc_plus2, valid}.
- One sub-module, `if_id_reg`: the IF/ID pipeline register, with load, hold and bubble controls. The PC register and FSM stay in `if_stage`.

## Test plan
- Reset sequence: `rst_n`=0 for 2 edges, then 1, with imem holding ADDs → `pc` goes 0000, 0002, 0004; `if_id_valid`=1 from the first edge after release; `if_id_pc_plus2` tracks 0002, 0004.
- Stall: 3-cycle stall at `pc`=0006 → `pc` and IF/ID unchanged for 3 edges, then resume at 0008.
- Redirect vs stall: `redirect`=1 with `redirect_pc`=0040 and `stall`=1 in the same cycle → `pc`=0040, `if_id_valid`=0, then the instruction at 0040 is in IF/ID one edge later.
- Halt: F000 at 0010 → IF/ID holds F000 with valid 1, `fetch_halted`=1, `pc` stays 0010, bubbles thereafter. Then a redirect to 0020 → RUN, `pc`=0020.
- Wrap: `redirect_pc`=FFFE holding an ADD → next `pc`=0000 and `if_id_pc_plus2`=0000.
- Reset mid-halt and mid-stall: `rst_n`=0 on one edge → all outputs at reset values; with `IF_STAGE_PERF_EN`, the counters read 0.
